rca_serial_adder: RTL and testbench
===================================

# rca_serial_adder

Parametrised multi-cycle ripple-carry adder/subtractor. Processes a WIDTH-bit operand pair DIGIT bits per clock, one digit-slice ripple adder per cycle, with the carry held in a register between cycles. Valid/ready handshakes on input and output let arithmetic datapaths trade area for latency. It replaces fixed 4-bit combinational ripple adders wherever wider operands, subtraction or flow control are needed.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0: s = a + b + cin; 1: s = a − b − cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out; for subtract, 1 means no borrow.
- ovf  output  1  signed (two's-complement) overflow.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid && in_ready:
  - Latch a into the A shift register.
  - Latch b into the B shift register; for sub=1, latch ~b instead.
  - Initialise the carry register to cin ^ sub.
  - Latch the operand MSBs a[WIDTH-1] and the effective b[WIDTH-1].
  - Clear the digit counter, then go to BUSY.
- BUSY, each cycle:
  - Add the low DIGIT bits of A and B plus the carry register.
  - Shift the DIGIT-bit sum into the result register from the top.
  - Shift A and B right by DIGIT bits.
  - Store the digit carry-out in the carry register.
  - Increment the counter. After the N-th digit, go to DONE.
- DONE:
  - out_valid=1; s holds the result register, cout the final carry.
  - ovf = carry into MSB ^ cout, where carry into MSB = a_msb ^ b_msb ^ s[WIDTH-1].
  - When out_valid && out_ready, go to IDLE.
- Arithmetic is modulo 2^WIDTH. Subtract is computed as a + ~b + ~cin.
- s, cout and ovf are registered. They change only on the DONE entry edge and are otherwise stable, including across IDLE until the next result.
- in_valid, a, b, cin and sub are ignored outside IDLE. Operand changes after acceptance have no effect.

## Timing
- Reset values:
  - State IDLE.
  - out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Shift, carry and counter registers cleared.
- rst takes priority over every other event in the same cycle.
- Latency: operands accepted at edge E0 give out_valid=1 after edge E0+N.
- If out_ready is high in the DONE cycle, return to IDLE at E0+N+1 and accept the next operands at E0+N+1 or later. Best-case initiation interval is N+1 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with s, cout and ovf stable and in_ready=0.
- out_ready asserted while not in DONE has no effect.
- N=1 (WIDTH==DIGIT): exactly one BUSY cycle, so out_valid asserts one cycle after acceptance.
- Reset mid-operation (BUSY or DONE): operation abandoned, out_valid=0 next cycle, no late result emitted.
- Digit counter width is clog2(N) bits, minimum 1. The terminal count is N−1 and does not wrap into a further BUSY cycle.

## Test plan
- WIDTH=16, DIGIT=4, add 0xFFFF + 0x0001, cin=0 -> after 4 cycles s=0x0000, cout=1, ovf=0; in_ready low for 5 cycles including DONE.
- Add 0x7FFF + 0x0001, cin=0 -> s=0x8000, cout=0, ovf=1. Add 0x1234 + 0x4321, cin=1 -> s=0x5556, cout=0, ovf=0.
- Subtract 0x0005 − 0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0. Subtract 0x8000 − 0x0001 -> s=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid, a and b -> s, cout and ovf stable, in_ready=0, no new acceptance. Raise out_ready -> IDLE next cycle, next operands accepted.
- Assert rst for 1 cycle during the 2nd BUSY cycle -> out_valid stays 0, s=0, IDLE with in_ready=1 after reset. A fresh add 0x0001 + 0x0001 then yields s=0x0002.
- WIDTH=4, DIGIT=4: add 0xF + 0x0, cin=1 -> out_valid one cycle after acceptance, s=0x0, cout=1, ovf=0.

Source files
------------

// File: rtl/rca_serial_adder.sv
// rtl/rca_serial_adder.sv - multi-cycle digit-serial ripple-carry adder/subtractor
// with valid/ready handshakes.
module rca_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_shift;

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
  // Result fills from the top so the first (least significant) digit ends up at bit 0.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~cin, so invert b and fold sub into the carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1] ^ sub;
          res_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = digit_sum[DIGIT];
        if (cnt_q == LAST) begin
          s_d     = res_shift;
          cout_d  = digit_sum[DIGIT];
          ovf_d   = a_msb_q ^ b_msb_q ^ res_shift[WIDTH-1] ^ digit_sum[DIGIT];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_serial_adder.sv
// tb/tb_rca_serial_adder.sv - directed table-driven bench for rca_serial_adder
// (16/4 instance plus a 4/4 single-digit instance).
module tb_rca_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, s;

  logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf;
  logic [3:0]  n_a, n_b, n_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rca_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  rca_serial_adder #(.WIDTH(4), .DIGIT(4)) dut_n1 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .s(n_s), .cout(n_cout), .ovf(n_ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at a negedge with the result consumed.
  task automatic run_op(input vec_t v, input string tag);
    int k;
    int low;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " accept_ready"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
    k = 0;
    low = 0;
    while (!out_valid && k < 20) begin
      if (!in_ready) low++;
      @(negedge clk);
      k++;
    end
    if (!in_ready) low++;
    chk({tag, " latency"}, 32'(k), 32'd4);
    chk({tag, " in_ready_low"}, 32'(low), 32'd5);
    chk({tag, " s"}, 32'(s), 32'(v.s));
    chk({tag, " cout"}, 32'(cout), 32'(v.cout));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " s_held"}, 32'(s), 32'(v.s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int bad;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0003, 16'h0003, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0; n_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset s", 32'(s), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset n1 in_ready", 32'(n_in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE while operand inputs churn.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk("bp reached_done", 32'(out_valid), 32'd1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = k[0]; a = 16'hA5A5 ^ 16'(k); b = 16'h5A5A + 16'(k); sub = k[1];
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 16'h3333 ||
          cout !== 1'b0 || ovf !== 1'b0) bad++;
    end
    chk("bp stable_cycles_bad", 32'(bad), 32'd0);
    chk("bp s", 32'(s), 32'h3333);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    v = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    run_op(v, "bp next");

    // Reset during the second BUSY cycle.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst s", 32'(s), 32'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("midrst no_late_result", 32'(bad), 32'd0);
    v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    run_op(v, "post rst");

    // Single-digit instance: one BUSY cycle.
    n_a = 4'hF; n_b = 4'h0; n_cin = 1'b1; n_sub = 1'b0; n_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_in_valid = 1'b0;
    chk("n1 busy out_valid", 32'(n_out_valid), 32'd0);
    chk("n1 busy in_ready", 32'(n_in_ready), 32'd0);
    @(negedge clk);
    chk("n1 out_valid", 32'(n_out_valid), 32'd1);
    chk("n1 s", 32'(n_s), 32'h0);
    chk("n1 cout", 32'(n_cout), 32'd1);
    chk("n1 ovf", 32'(n_ovf), 32'd0);
    n_out_ready = 1'b1;
    @(negedge clk);
    n_out_ready = 1'b0;
    chk("n1 idle in_ready", 32'(n_in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
